// File: rtl/md_sequencer.sv
// E-stage multiply/divide sequencer: launches mult/div, times them, commits HI/LO.
// Divider hardware is compiled only when MD_DIV_EN is defined.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] INSTR_E,
  input  logic        valid_E,
  input  logic        md_D,
  input  logic [31:0] rs_val_E,
  input  logic [31:0] rt_val_E,
  output logic        start,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] md_out_E,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CMAX =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(CMAX + 1);

  logic [5:0] op;
  logic [5:0] fn;
  logic       special;
  logic       unused_bits;

  logic is_mult, is_multu, is_div, is_divu;
  logic is_mfhi, is_mthi, is_mflo, is_mtlo;

  logic [CW-1:0] cnt;
  logic [CW-1:0] load;
  logic [31:0]   p_hi, p_lo;
  logic [31:0]   p_hi_d, p_lo_d;
  logic [63:0]   prod_s, prod_u;

  assign op          = INSTR_E[31:26];
  assign fn          = INSTR_E[5:0];
  assign special     = (op == 6'b000000);
  assign unused_bits = ^INSTR_E[25:6];

  assign is_mult  = special & (fn == 6'b011000);
  assign is_multu = special & (fn == 6'b011001);
  assign is_mfhi  = special & (fn == 6'b010000);
  assign is_mthi  = special & (fn == 6'b010001);
  assign is_mflo  = special & (fn == 6'b010010);
  assign is_mtlo  = special & (fn == 6'b010011);

  assign prod_s = $signed({{32{rs_val_E[31]}}, rs_val_E})
                * $signed({{32{rt_val_E[31]}}, rt_val_E});
  assign prod_u = {32'b0, rs_val_E} * {32'b0, rt_val_E};

`ifdef MD_DIV_EN
  logic               dz;
  logic [31:0]        dvs;
  logic signed [31:0] sq, sr;
  logic [31:0]        uq, ur;

  assign is_div  = special & (fn == 6'b011010);
  assign is_divu = special & (fn == 6'b011011);

  // Divisor forced to 1 on zero so the divider never sees /0
  assign dz  = (rt_val_E == 32'd0);
  assign dvs = dz ? 32'd1 : rt_val_E;
  assign sq  = $signed(rs_val_E) / $signed(dvs);
  assign sr  = $signed(rs_val_E) % $signed(dvs);
  assign uq  = rs_val_E / dvs;
  assign ur  = rs_val_E % dvs;
`else
  assign is_div  = 1'b0;
  assign is_divu = 1'b0;
`endif

  assign start = valid_E & ~busy
               & (is_mult | is_multu | is_div | is_divu);
  assign md_stall = md_D & (start | busy);

  always_comb begin
    p_hi_d = HI;
    p_lo_d = LO;
    load   = CW'(MULT_CYCLES);
    unique case (1'b1)
      is_mult:  {p_hi_d, p_lo_d} = prod_s;
      is_multu: {p_hi_d, p_lo_d} = prod_u;
`ifdef MD_DIV_EN
      is_div: begin
        load = CW'(DIV_CYCLES);
        if (!dz) begin
          p_hi_d = sr;
          p_lo_d = sq;
        end
      end
      is_divu: begin
        load = CW'(DIV_CYCLES);
        if (!dz) begin
          p_hi_d = ur;
          p_lo_d = uq;
        end
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    md_out_E = 32'd0;
    unique case (1'b1)
      is_mfhi: md_out_E = HI;
      is_mflo: md_out_E = LO;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      HI   <= 32'd0;
      LO   <= 32'd0;
      p_hi <= 32'd0;
      p_lo <= 32'd0;
    end else if (busy) begin
      if (cnt == CW'(1)) begin
        HI   <= p_hi;
        LO   <= p_lo;
        busy <= 1'b0;
      end
      cnt <= cnt - CW'(1);
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= load;
      p_hi <= p_hi_d;
      p_lo <= p_lo_d;
    end else if (valid_E) begin
      if (is_mthi) HI <= rs_val_E;
      if (is_mtlo) LO <= rs_val_E;
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: cycle model with per-cycle compare plus literal checks.
// Div scenarios run only when MD_DIV_EN is defined.
module tb_md_sequencer;

  localparam int MC = 5;
  localparam int DC = 10;
`ifdef MD_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] MULT  = 32'h0085_0018;
  localparam logic [31:0] MULTU = 32'h0085_0019;
  localparam logic [31:0] DIV   = 32'h0085_001A;
  localparam logic [31:0] DIVU  = 32'h0085_001B;
  localparam logic [31:0] MFHI  = 32'h0000_4010;
  localparam logic [31:0] MTHI  = 32'h0080_0011;
  localparam logic [31:0] MFLO  = 32'h0000_4012;
  localparam logic [31:0] MTLO  = 32'h0080_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] INSTR_E;
  logic        valid_E;
  logic        md_D;
  logic [31:0] rs_val_E;
  logic [31:0] rt_val_E;
  logic        start;
  logic        busy;
  logic        md_stall;
  logic [31:0] md_out_E;
  logic [31:0] HI;
  logic [31:0] LO;

  md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .INSTR_E(INSTR_E), .valid_E(valid_E),
    .md_D(md_D), .rs_val_E(rs_val_E), .rt_val_E(rt_val_E),
    .start(start), .busy(busy), .md_stall(md_stall),
    .md_out_E(md_out_E), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mthi, 7 mflo, 8 mtlo
  function automatic int kind(input logic [31:0] i);
    if (i[31:26] != 6'd0) return 0;
    case (i[5:0])
      6'h18: return 1;
      6'h19: return 2;
      6'h1A: return 3;
      6'h1B: return 4;
      6'h10: return 5;
      6'h11: return 6;
      6'h12: return 7;
      6'h13: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic bit launches(input int k);
    return (k == 1) || (k == 2) || (DIV_EN && (k == 3 || k == 4));
  endfunction

  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  int          m_rem = 0;
  int          mk;
  logic [63:0] mp;
  longint      sa, sb;
  int          ia, ib;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (valid_E) begin
      mk = kind(INSTR_E);
      if (launches(mk)) begin
        m_rem = (mk <= 2) ? MC : DC;
        if (mk == 1) begin
          sa = longint'(int'(rs_val_E));
          sb = longint'(int'(rt_val_E));
          mp = sa * sb;
        end else if (mk == 2) begin
          mp = {32'b0, rs_val_E} * {32'b0, rt_val_E};
        end else if (rt_val_E == 0) begin
          mp = {m_hi, m_lo};
        end else if (mk == 3) begin
          ia = rs_val_E;
          ib = rt_val_E;
          mp = {32'(ia % ib), 32'(ia / ib)};
        end else begin
          mp = {rs_val_E % rt_val_E, rs_val_E / rt_val_E};
        end
        m_phi = mp[63:32];
        m_plo = mp[31:0];
      end else if (mk == 6) begin
        m_hi = rs_val_E;
      end else if (mk == 8) begin
        m_lo = rs_val_E;
      end
    end
  end

  int          ck;
  logic        e_start;
  logic [31:0] e_out;

  always @(negedge clk) begin
    ck      = kind(INSTR_E);
    e_start = valid_E && (m_rem == 0) && launches(ck);
    e_out   = (ck == 5) ? m_hi : (ck == 7) ? m_lo : 32'd0;
    chk("cyc_start", start, e_start);
    chk("cyc_busy", busy, m_rem > 0);
    chk("cyc_stall", md_stall, md_D && (e_start || m_rem > 0));
    chk("cyc_out", md_out_E, e_out);
    chk("cyc_hi", HI, m_hi);
    chk("cyc_lo", LO, m_lo);
  end

  task automatic set_in(input logic [31:0] ins, input logic v,
                        input logic d, input logic [31:0] rs,
                        input logic [31:0] rt);
    INSTR_E  = ins;
    valid_E  = v;
    md_D     = d;
    rs_val_E = rs;
    rt_val_E = rt;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic nop;
    set_in(NOP, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    nop();
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    reset = 1'b0;
    tick();

    // signed mult
    set_in(MULT, 1, 0, 32'hFFFF_FFFE, 32'd3);
    #1 chk("mult_start", start, 1);
    tick();
    nop();
    for (int i = 1; i <= MC; i++) begin
      chk("mult_busy", busy, 1);
      tick();
    end
    chk("mult_done", busy, 0);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);

    // unsigned mult
    set_in(MULTU, 1, 0, 32'hFFFF_FFFE, 32'd3);
    tick();
    nop();
    repeat (MC) tick();
    chk("multu_hi", HI, 32'h0000_0002);
    chk("multu_lo", LO, 32'hFFFF_FFFA);

    // stall window with md_D held
    set_in(MULT, 1, 1, 32'h0001_0000, 32'h0003_0000);
    #1 chk("stall_T", md_stall, 1);
    tick();
    set_in(NOP, 0, 1, 32'd0, 32'd0);
    for (int i = 1; i <= MC; i++) begin
      chk("stall_busy", md_stall, 1);
      tick();
    end
    chk("stall_end", md_stall, 0);
    set_in(MFHI, 1, 0, 32'd0, 32'd0);
    #1 chk("mfhi_after", md_out_E, 32'd3);
    tick();

    // mthi then mflo/mfhi
    set_in(MTHI, 1, 0, 32'h1234_5678, 32'd0);
    tick();
    set_in(MFLO, 1, 0, 32'd0, 32'd0);
    #1 chk("mflo_unch", md_out_E, 32'd0);
    tick();
    set_in(MFHI, 1, 0, 32'd0, 32'd0);
    #1 chk("mfhi_new", md_out_E, 32'h1234_5678);
    chk("mthi_lo", LO, 32'd0);
    tick();

    set_in(MTLO, 1, 0, 32'hCAFE_BABE, 32'd0);
    tick();
    set_in(MFLO, 1, 0, 32'd0, 32'd0);
    #1 chk("mtlo_rd", md_out_E, 32'hCAFE_BABE);
    tick();

    // bubble with mult encoding
    set_in(MULT, 0, 0, 32'd5, 32'd5);
    #1 chk("bub_start", start, 0);
    tick();
    chk("bub_busy", busy, 0);
    chk("bub_lo", LO, 32'hCAFE_BABE);

    // mult presented while busy does not restart
    set_in(MULT, 1, 0, 32'd2, 32'd3);
    tick();
    set_in(MULT, 1, 0, 32'd7, 32'd7);
    repeat (MC) tick();
    chk("nrst_lo", LO, 32'd6);
    chk("nrst_hi", HI, 32'd0);
    nop();
    tick();

`ifdef MD_DIV_EN
    set_in(DIV, 1, 0, 32'hFFFF_FFF9, 32'd2);
    tick();
    nop();
    for (int i = 1; i <= DC; i++) begin
      chk("div_busy", busy, 1);
      tick();
    end
    chk("div_done", busy, 0);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);
    set_in(DIVU, 1, 0, 32'd7, 32'd0);
    tick();
    nop();
    repeat (DC) tick();
    chk("div0_hi", HI, 32'hFFFF_FFFF);
    chk("div0_lo", LO, 32'hFFFF_FFFD);
`else
    set_in(DIV, 1, 0, 32'd9, 32'd3);
    #1 chk("nodiv_start", start, 0);
    tick();
    set_in(DIVU, 1, 0, 32'd9, 32'd3);
    #1 chk("nodivu_start", start, 0);
    tick();
    nop();
    chk("nodiv_busy", busy, 0);
    chk("nodiv_hi", HI, 32'd0);
    chk("nodiv_lo", LO, 32'd6);
`endif

    // reset in the middle of an operation
    set_in(MTHI, 1, 0, 32'hA5A5_A5A5, 32'd0);
    tick();
    if (DIV_EN) set_in(DIV, 1, 0, 32'd100, 32'd7);
    else set_in(MULT, 1, 0, 32'hFFFF_FFFE, 32'd3);
    tick();
    nop();
    tick();
    reset = 1'b1;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_hi", HI, 32'd0);
    chk("mrst_lo", LO, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    repeat (DC + 2) tick();
    chk("post_busy", busy, 0);
    chk("post_hi", HI, 32'd0);
    chk("post_lo", LO, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

E-stage multiply/divide sequencer for the pipelined MIPS core. Decodes the E-stage instruction, launches multi-cycle mult/multu/div/divu operations, counts their latency, and commits results to the HI/LO registers. Serves mfhi/mflo/mthi/mtlo. Produces the D-stage stall request that holds any HI/LO instruction while an operation is pending.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- INSTR_E  in  32  instruction currently in E
- valid_E  in  1  E instruction is real (0 = bubble/flushed); no launch or write when 0
- md_D  in  1  D-stage instruction is one of the eight HI/LO instructions
- rs_val_E  in  32  forwarded rs operand
- rt_val_E  in  32  forwarded rt operand
- start  out  1  combinational; high in the cycle a mult/div launches
- busy  out  1  registered; operation in flight
- md_stall  out  1  combinational; md_D & (start | busy)
- md_out_E  out  32  combinational; HI for mfhi, LO for mflo, else 0
- HI, LO  out  32 each  architectural registers

## Operation
- Decode (opcode 000000): mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
- start = valid_E & !busy & (mult|multu|div|divu).
- On start, compute the result from rs_val_E/rt_val_E into the pending registers pHI/pLO.
  - mult/multu: 64-bit signed/unsigned product; pHI = [63:32], pLO = [31:0].
  - div/divu: pLO = quotient, pHI = remainder. Signed division truncates toward zero; remainder takes the sign of the dividend.
  - Divisor 0: pHI/pLO = current HI/LO, so the architectural registers are unchanged. Full DIV_CYCLES busy still applies.
- Counter: loaded with MULT_CYCLES or DIV_CYCLES on start, decremented each busy cycle.
  - When busy & cnt==1: HI <= pHI, LO <= pLO, busy <= 0.
- mthi/mtlo: when valid_E & !busy, HI <= rs_val_E or LO <= rs_val_E at the edge.
  - Ignored when busy; unreachable when md_stall is honored.
- A mult/div in E while busy is ignored and does not restart.
- The pipeline guarantees this through md_stall.
- md_out_E reads the architectural HI/LO, never pending values.

## Timing
- Reset values: busy=0, cnt=0, HI=LO=pHI=pLO=0. start, md_stall and md_out_E follow from inputs.
- Launch in cycle T: busy is high T+1 .. T+N (N = MULT_CYCLES or DIV_CYCLES).
- HI/LO are updated at the edge ending T+N. The first cycle HI/LO and !busy are visible is T+N+1.
- md_stall is high in T (via start) and T+1 .. T+N; a waiting D-stage HI/LO instruction enters E at T+N+1.
- mthi/mtlo take effect at the edge ending the cycle they are in E; mfhi in the next cycle reads the new value.
- Reset asserted mid-operation: busy drops immediately and the pending result is discarded. HI/LO become 0 and no commit occurs after reset release.
- valid_E=0 with a mult/div encoding: no start and no state change.

## Configuration
- MD_DIV_EN defined: div/divu behave as above.
- MD_DIV_EN undefined: the divider logic is not compiled.
  - div/divu decode as no-ops: no start, no busy, HI/LO unchanged.
  - DIV_CYCLES is unused.

## Test plan
- Reset, then mult with rs=0xFFFFFFFE, rt=3:
  - start=1 at T and busy=1 for T+1..T+5.
  - At T+6, HI=0xFFFFFFFF and LO=0xFFFFFFFA.
  - multu with the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- div rs=-7 (0xFFFFFFF9), rt=2: busy for 10 cycles, then LO=0xFFFFFFFD (-3) and HI=0xFFFFFFFF (-1). divu 7/0: HI/LO unchanged after 10 busy cycles.
- md_D=1 held from T through a mult launch: md_stall=1 for T..T+5 and 0 at T+6. mfhi issued afterwards returns the committed HI.
- mthi rs=0x12345678, then mflo and mfhi in the next cycles:
  - HI=0x12345678, LO unchanged.
  - md_out_E=0x12345678 for the mfhi.
- Assert reset at T+2 of a div: busy=0 immediately and HI=LO=0. No update occurs after release.
- Build without MD_DIV_EN: div rs=9, rt=3 gives start=0, busy=0 and HI/LO unchanged. mult still behaves as in the first scenario.
